// File: rtl/mul_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiplier.
package mul_unit_pkg;

  typedef enum logic [2:0] {
    MUL_LO = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  localparam int MUL_CYCLES = 34;

  // Two's-complement magnitude; the most negative value maps to itself as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_unit.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU, fixed 34-cycle latency.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  mul_state_t       state, state_nxt;
  mul_op_t          op_q;
  logic [XLEN-1:0]  mag_a;
  logic             neg_q;
  logic [2*XLEN:0]  prod;
  logic [CW-1:0]    cnt;

  logic             accept;
  mul_op_t          op_in;
  logic [XLEN:0]    sum;
  logic [2*XLEN:0]  prod_add;
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]  res_sel;

  assign op_in  = mul_op_t'(func3);
  assign accept = (state == IDLE) && start && !func3[2] && !flush;

  // Combinational so the hazard unit can stall in the request cycle itself.
  assign busy = accept || (state == CALC) || (state == SIGN);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (cnt == '0) state_nxt = SIGN;
      SIGN: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush && state != IDLE) state_nxt = IDLE;
  end

  // Datapath combinational terms
  always_comb begin
    sum      = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, mag_a};
    prod_add = prod[0] ? {sum, prod[XLEN-1:0]} : prod;
    prod_fin = neg_q ? (~prod[2*XLEN-1:0] + 1'b1) : prod[2*XLEN-1:0];
    res_sel  = (op_q == MUL_LO) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
  end

  // Operand latch, shift-add iteration and sign fix-up
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q  <= MUL_LO;
      mag_a <= '0;
      neg_q <= 1'b0;
      prod  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q  <= op_in;
          mag_a <= (op_in == MULH || op_in == MULHSU) ? abs32(a) : a;
          prod  <= {{(XLEN+1){1'b0}}, (op_in == MULH) ? abs32(b) : b};
          cnt   <= CW'(XLEN-1);
          case (op_in)
            MULH:    neg_q <= a[XLEN-1] ^ b[XLEN-1];
            MULHSU:  neg_q <= a[XLEN-1];
            default: neg_q <= 1'b0;
          endcase
        end
        CALC: begin
          prod <= prod_add >> 1;
          cnt  <= cnt - 1'b1;
        end
        SIGN: prod[2*XLEN-1:0] <= prod_fin;
        default: ;
      endcase
    end
  end

  // Outputs registered on the edge entering DONE; result holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= (state_nxt == DONE);
      if (state == SIGN && state_nxt == DONE) result <= res_sel;
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Directed-vector bench for mul_unit: latency, op variants, flush, reset, divide encodings.
module tb_mul_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  mul_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func3(func3), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Issue one op, wait (bounded) for done, check latency and result.
  task automatic run_mul(input string tag, input logic [2:0] op,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] exp);
    int lat;
    lat = 0;
    next_cycle();
    start = 1'b1; func3 = op; a = va; b = vb;
    @(negedge clk);
    chk({tag, "_busy_req"}, {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 60; k++) begin
      next_cycle();
      start = 1'b0;
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    chk({tag, "_lat"}, lat, 32'd34);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int busy_cnt, early_done, done_seen;
    rst_n = 1'b0; start = 1'b0; func3 = 3'b000; a = '0; b = '0; flush = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    next_cycle(); rst_n = 1'b1;

    // 1: MUL 7*6 with per-cycle busy/done tracking
    next_cycle();
    start = 1'b1; func3 = 3'b000; a = 32'd7; b = 32'd6;
    @(negedge clk);
    chk("t1_busy_C", {31'd0, busy}, 32'd1);
    busy_cnt = 0; early_done = 0;
    for (int k = 1; k <= 33; k++) begin
      next_cycle(); start = 1'b0;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) early_done++;
    end
    chk("t1_busy_cycles", busy_cnt, 32'd33);
    chk("t1_early_done", early_done, 32'd0);
    next_cycle(); @(negedge clk);
    chk("t1_done_C34", {31'd0, done}, 32'd1);
    chk("t1_busy_C34", {31'd0, busy}, 32'd0);
    chk("t1_result", result, 32'h0000002A);
    next_cycle(); @(negedge clk);
    chk("t1_done_C35", {31'd0, done}, 32'd0);
    chk("t1_result_hold", result, 32'h0000002A);

    // 2, 3: op variants
    run_mul("mul_m1x2",    3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE);
    run_mul("mulh_m1x2",   3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
    run_mul("mulhu_m1x2",  3'b011, 32'hFFFFFFFF, 32'h00000002, 32'h00000001);
    run_mul("mulhu_m1m1",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_mul("mulh_m1m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    run_mul("mulhsu_m1m1", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_mul("mulh_min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000);

    // 4: flush at C+10, restart at C+12 (previous result 0x40000000)
    next_cycle();
    start = 1'b1; func3 = 3'b000; a = 32'd3; b = 32'd5;
    for (int k = 1; k <= 9; k++) begin next_cycle(); start = 1'b0; end
    next_cycle(); flush = 1'b1;
    @(negedge clk);
    chk("t4_busy_C10", {31'd0, busy}, 32'd1);
    next_cycle(); flush = 1'b0;
    @(negedge clk);
    chk("t4_busy_C11", {31'd0, busy}, 32'd0);
    chk("t4_done_C11", {31'd0, done}, 32'd0);
    chk("t4_result_kept", result, 32'h40000000);
    // run_mul starts in the next cycle, i.e. C+12; done 34 later = C+46
    run_mul("t4_restart", 3'b000, 32'd3, 32'd5, 32'h0000000F);

    // 5: reset at C+20 mid-CALC
    next_cycle();
    start = 1'b1; func3 = 3'b000; a = 32'd9; b = 32'd9;
    for (int k = 1; k <= 19; k++) begin next_cycle(); start = 1'b0; end
    next_cycle(); rst_n = 1'b0;
    next_cycle(); rst_n = 1'b1;
    @(negedge clk);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_result", result, 32'd0);
    run_mul("t5_after", 3'b000, 32'd2, 32'd2, 32'h00000004);

    // 6: divide encoding ignored
    next_cycle();
    start = 1'b1; func3 = 3'b100; a = 32'd10; b = 32'd3;
    @(negedge clk);
    chk("t6_busy_req", {31'd0, busy}, 32'd0);
    busy_cnt = 0; done_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      next_cycle(); start = 1'b0;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_seen++;
    end
    chk("t6_busy_after", busy_cnt, 32'd0);
    chk("t6_no_done", done_seen, 32'd0);
    chk("t6_result_hold", result, 32'h00000004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative RV32M multiplier that services the execute stage's multiply request and answers on the pipeline's `mul_busy` / `mul_res` handshake. It implements MUL, MULH, MULHSU and MULHU with a radix-2 shift-add datapath of fixed 34-cycle latency. Execute raises `start` with operands and `func3`. The unit holds `busy` so hazard logic stalls fetch, decode and execute, then pulses `done` with the 32-bit result.

## Interface
- `XLEN`, default 32: operand/result width.
- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: execute-stage request for a multiply; sampled only in IDLE.
- `func3` input 3: operation; 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- `a` input XLEN: rs1 operand (forwarded value, `r1_e_mux`).
- `b` input XLEN: rs2 operand (forwarded value, `r2_e_mux`).
- `flush` input 1: abort the in-flight operation (execute-stage flush).
- `busy` output 1: drives pipeline `mul_busy`.
- `done` output 1: one-cycle pulse; `result` valid.
- `result` output XLEN: drives `mul_res`; registered and held until the next accepted start.

## Operation
- States are IDLE, CALC, SIGN and DONE.
- **IDLE**
  - `start` with `func3[2]==0` is accepted.
  - On accept, latch `func3`.
  - Latch magnitudes: `|a|` if op is MULH/MULHSU, else `a`; `|b|` if op is MULH, else `b`.
  - Latch the negate flag: `a[31]^b[31]` for MULH, `a[31]` for MULHSU, 0 otherwise.
  - Load `prod[64:0] = {33'b0, mag_b}`, set `cnt = 31`, go to CALC.
- `start` with `func3[2]==1` (divide encodings) is ignored. The unit stays in IDLE and never asserts `busy` or `done`.
- **CALC**, each cycle:
  - If `prod[0]`: `prod[64:32] = prod[63:32] + mag_a`, a 33-bit sum.
  - Then shift `prod` right by 1.
  - Decrement `cnt`. At `cnt==0`, go to SIGN.
- **SIGN**: if the negate flag is set, `prod[63:0] = ~prod[63:0] + 1`. Go to DONE.
- **DONE**
  - `result = prod[31:0]` for MUL, else `prod[63:32]`; loaded on entry.
  - `done=1` for this cycle only. Next state is IDLE.
- Magnitude of 0x80000000 is 0x80000000 as unsigned; no overflow special-case.
- `start` while not in IDLE is ignored; the pipeline is stalled, so it must not occur.
- **flush** in CALC/SIGN/DONE: next state is IDLE, and `done` is not asserted in the following cycle. `result` keeps its previous value. Flush has priority over every transition.
- **flush with start in IDLE**: the start is not accepted.
- **Reset** at any time, including mid-CALC: state IDLE, `busy=0`, `done=0`, `result=0`, `prod=0`, `cnt=0`.

## Timing
- `busy` is combinational and defined as `(IDLE & start & ~func3[2] & ~flush) | CALC | SIGN`. This lets the hazard unit stall in the request cycle.
- Let C be the cycle in which start is accepted.
  - C+1 through C+32: CALC.
  - C+33: SIGN.
  - C+34: DONE, with `done=1` and `busy=0`; execute advances this cycle.
- `busy` is high from C through C+33, i.e. 34 cycles.
- Earliest next accept is C+35; back-to-back spacing is 35 cycles.
- The `result` register updates only on the clock edge entering DONE. `done` and `result` are registered outputs.

## Structure
- Add to `defs.svh`:
  - `mul_op_t` enum (MUL_LO=3'b000, MULH=3'b001, MULHSU=3'b010, MULHU=3'b011);
  - `mul_state_t` enum (IDLE, CALC, SIGN, DONE);
  - `localparam MUL_CYCLES = 34`.
- Single flat module `mul_unit`, with no sub-module. The counter, datapath and FSM are each too small to justify splitting.
- Instantiated beside the ALU in execute. Its outputs connect to the pipeline's `mul_busy` and `mul_res[E]`.

## Test plan
1. MUL, a=7, b=6, start at C: busy high C..C+33; done=1 only at C+34; result=0x0000002A.
2. a=0xFFFFFFFF, b=0x00000002: MUL gives result=0xFFFFFFFE; MULH gives result=0xFFFFFFFF; MULHU gives result=0x00000001.
3. a=b=0xFFFFFFFF: MULHU gives 0xFFFFFFFE; MULH gives 0x00000000; MULHSU gives 0xFFFFFFFF. a=b=0x80000000 with MULH gives 0x40000000.
4. MUL 3×5 started at C, flush at C+10: busy=0 from C+11, no done pulse, result unchanged. New MUL 3×5 at C+12 gives done at C+46 with result=0x0000000F.
5. rst_n=0 at C+20 mid-CALC: at C+21 busy=0, done=0, result=0. After release, a normal MUL 2×2 returns 0x00000004 at 34 cycles.
6. start with func3=3'b100: busy stays 0 in the request cycle and after, done never pulses, state stays IDLE.
